dpack_param: RTL and testbench

Parametrised beat-to-word packer. It concatenates RATIO consecutive IN_W-bit input beats into one IN_W*RATIO-bit output word. It adds a valid/ready handshake with backpressure on both sides, selectable lane order, and a flush that emits a partial word with a per-lane keep mask. It sits between narrow byte/sample sources and the wide word-oriented datapath, and replaces fixed-ratio packers.

---
 rtl/dpack_param_if.sv | 31 +++
 rtl/dpack_param.sv | 92 +++++++++
 tb/tb_dpack_param.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dpack_param_if.sv
// Beat-side and word-side handshake bundle for the beat-to-word packer.
// Carries no state; the packer is the slave, the source/sink side is the master.
// Widths follow the packer parameters so one interface type serves any ratio.
interface dpack_param_if #(
   parameter int IN_W  = 8,
   parameter int RATIO = 4
);
   logic                    sync_n;
   logic [IN_W-1:0]         data_in;
   logic                    data_in_valid;
   logic                    data_in_ready;
   logic                    flush;
   logic                    flush_ack;
   logic [IN_W*RATIO-1:0]   data_out;
   logic [RATIO-1:0]        data_out_keep;
   logic                    data_out_last;
   logic                    data_out_valid;
   logic                    data_out_ready;

   modport master (
      output sync_n, data_in, data_in_valid, flush, data_out_ready,
      input  data_in_ready, flush_ack, data_out, data_out_keep,
             data_out_last, data_out_valid
   );

   modport slave (
      input  sync_n, data_in, data_in_valid, flush, data_out_ready,
      output data_in_ready, flush_ack, data_out, data_out_keep,
             data_out_last, data_out_valid
   );
endinterface

// File: rtl/dpack_param.sv
// Packs RATIO consecutive IN_W-bit beats into one word; flush emits a partial word with keep.
// Latency: word valid the cycle after the edge accepting its last beat (or the flush).
// Backpressure: absorbs RATIO-1 beats while the output slot is full, then stalls the completing beat.
module dpack_param #(
   parameter int IN_W      = 8,
   parameter int RATIO     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic          sysclk,
   input logic          reset,
   dpack_param_if.slave bus
);
   localparam int W  = IN_W * RATIO;
   localparam int CW = $clog2(RATIO + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_beat;
   logic [W-1:0]     acc;
   logic [W-1:0]     acc_beat;
   logic [RATIO-1:0] keep_beat;
   logic             slot_free;
   logic             in_rdy;
   logic             f_ack;
   logic             take;
   logic             load_full;
   logic             load_flush;
   logic             load;

   // Lane that the k-th beat of a word lands in. The mapping is its own inverse,
   // so it also gives the beat index that fills a given lane.
   function automatic int lane(input int k);
      return MSB_FIRST ? (RATIO - 1 - k) : k;
   endfunction

   // Handshake decisions and the accumulator as it would look with this cycle's beat folded in
   always_comb begin
      slot_free  = !bus.data_out_valid || bus.data_out_ready;
      in_rdy     = !reset && bus.sync_n &&
                   (slot_free || (cnt != LAST_CNT && !bus.flush));
      f_ack      = !reset && bus.sync_n && bus.flush && slot_free;
      take       = bus.data_in_valid && in_rdy;
      cnt_beat   = cnt + CW'(take);
      acc_beat   = acc;
      for (int i = 0; i < RATIO; i++) begin
         if (take && cnt == CW'(lane(i)))
            acc_beat[i*IN_W +: IN_W] = bus.data_in;
      end
      keep_beat  = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (CW'(k) < cnt_beat)
            keep_beat[lane(k)] = 1'b1;
      end
      load_full  = take && (cnt == LAST_CNT);
      load_flush = f_ack && (cnt_beat != '0);
      load       = load_full || load_flush;
   end

   assign bus.data_in_ready = in_rdy;
   assign bus.flush_ack     = f_ack;

   // Beat counter and partial-word accumulator; sync_n drops any partial word
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         acc <= '0;
      end else if (!bus.sync_n || load) begin
         cnt <= '0;
         acc <= '0;
      end else if (take) begin
         cnt <= cnt_beat;
         acc <= acc_beat;
      end
   end

   // One-entry output register: a load wins over a consume in the same cycle
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         bus.data_out       <= '0;
         bus.data_out_keep  <= '0;
         bus.data_out_last  <= 1'b0;
         bus.data_out_valid <= 1'b0;
      end else if (load) begin
         bus.data_out       <= acc_beat;
         bus.data_out_keep  <= keep_beat;
         bus.data_out_last  <= load_flush;
         bus.data_out_valid <= 1'b1;
      end else if (bus.data_out_ready) begin
         bus.data_out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_dpack_param.sv
// Directed bench for dpack_param: two instances (MSB-first and LSB-first) share one stimulus.
// Expected words are hand-computed constants.
// Summary line reports comparison and failure counts.
module tb_dpack_param;
   logic       sysclk;
   logic       rst;
   logic       sn;
   logic [7:0] din;
   logic       dvld;
   logic       fl;
   logic       ordy;

   int checks   = 0;
   int failures = 0;

   dpack_param_if #(.IN_W(8), .RATIO(4)) ifa ();
   dpack_param_if #(.IN_W(8), .RATIO(4)) ifb ();

   assign ifa.sync_n = sn;  assign ifa.data_in = din;  assign ifa.data_in_valid = dvld;
   assign ifa.flush = fl;   assign ifa.data_out_ready = ordy;
   assign ifb.sync_n = sn;  assign ifb.data_in = din;  assign ifb.data_in_valid = dvld;
   assign ifb.flush = fl;   assign ifb.data_out_ready = ordy;

   dpack_param #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b1)) dut_a (
      .sysclk(sysclk), .reset(rst), .bus(ifa));
   dpack_param #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b0)) dut_b (
      .sysclk(sysclk), .reset(rst), .bus(ifb));

   initial begin
      sysclk = 1'b0;
      forever #5 sysclk = ~sysclk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k,
                           input logic l);
      chk({tag, "_vld"},  ifa.data_out_valid, 1'b1);
      chk({tag, "_dat"},  ifa.data_out, d);
      chk({tag, "_keep"}, ifa.data_out_keep, k);
      chk({tag, "_last"}, ifa.data_out_last, l);
   endtask

   initial begin
      rst = 1'b1; sn = 1'b1; din = 8'h00; dvld = 1'b0; fl = 1'b1; ordy = 1'b1;
      step();
      step();
      // reset state
      chk("rst_vld",   ifa.data_out_valid, 1'b0);
      chk("rst_dat",   ifa.data_out, 32'h0);
      chk("rst_keep",  ifa.data_out_keep, 4'h0);
      chk("rst_last",  ifa.data_out_last, 1'b0);
      chk("rst_inrdy", ifa.data_in_ready, 1'b0);
      chk("rst_fack",  ifa.flush_ack, 1'b0);
      fl  = 1'b0;
      rst = 1'b0;
      #1;
      chk("post_rst_inrdy", ifa.data_in_ready, 1'b1);

      // full word, both lane orders
      dvld = 1'b1;
      din = 8'h11; step();
      din = 8'h22; step();
      din = 8'h33; step();
      chk("t1_not_yet", ifa.data_out_valid, 1'b0);
      din = 8'h44; step();
      dvld = 1'b0;
      chk_word("t1_msb", 32'h11223344, 4'hF, 1'b0);
      chk("t1_lsb_dat",  ifb.data_out, 32'h44332211);
      chk("t1_lsb_keep", ifb.data_out_keep, 4'hF);
      step();
      chk("t1_one_cycle", ifa.data_out_valid, 1'b0);

      // backpressure: bytes 01..08 with the sink stalled
      ordy = 1'b0;
      dvld = 1'b1;
      for (int b = 1; b <= 7; b++) begin
         din = 8'(b);
         #1;
         chk($sformatf("t3_rdy_%0d", b), ifa.data_in_ready, 1'b1);
         step();
      end
      din = 8'h08;
      #1;
      chk_word("t3_held", 32'h01020304, 4'hF, 1'b0);
      chk("t3_stall_08", ifa.data_in_ready, 1'b0);
      step();
      chk("t3_still_stall", ifa.data_in_ready, 1'b0);
      chk("t3_still_held", ifa.data_out, 32'h01020304);
      ordy = 1'b1;
      #1;
      chk("t3_rdy_08", ifa.data_in_ready, 1'b1);
      step();
      dvld = 1'b0;
      chk_word("t3_second", 32'h05060708, 4'hF, 1'b0);
      step();
      chk("t3_drained", ifa.data_out_valid, 1'b0);

      // partial word by flush
      dvld = 1'b1;
      din = 8'hAA; step();
      din = 8'hBB; step();
      din = 8'hCC; step();
      dvld = 1'b0;
      fl = 1'b1;
      #1;
      chk("t4_fack", ifa.flush_ack, 1'b1);
      step();
      fl = 1'b0;
      #1;
      chk("t4_fack_drop", ifa.flush_ack, 1'b0);
      chk_word("t4_flush", 32'hAABBCC00, 4'hE, 1'b1);
      chk("t4_lsb_dat",  ifb.data_out, 32'h00CCBBAA);
      chk("t4_lsb_keep", ifb.data_out_keep, 4'h7);
      step();
      chk("t4_drained", ifa.data_out_valid, 1'b0);
      fl = 1'b1;
      #1;
      chk("t4_empty_fack", ifa.flush_ack, 1'b1);
      step();
      fl = 1'b0;
      chk("t4_empty_noword", ifa.data_out_valid, 1'b0);

      // flush coinciding with an accepted beat
      dvld = 1'b1;
      din = 8'h66; step();
      din = 8'h55; fl = 1'b1;
      #1;
      chk("t5_rdy", ifa.data_in_ready, 1'b1);
      chk("t5_fack", ifa.flush_ack, 1'b1);
      step();
      dvld = 1'b0; fl = 1'b0;
      chk_word("t5_flush", 32'h66550000, 4'hC, 1'b1);
      // flush blocked while the slot is full
      ordy = 1'b0; dvld = 1'b1; din = 8'h77; fl = 1'b1;
      #1;
      chk("t5_blk_fack", ifa.flush_ack, 1'b0);
      chk("t5_blk_rdy",  ifa.data_in_ready, 1'b0);
      step();
      chk("t5_blk_hold", ifa.data_out, 32'h66550000);
      ordy = 1'b1;
      #1;
      chk("t5_unblk_fack", ifa.flush_ack, 1'b1);
      chk("t5_unblk_rdy",  ifa.data_in_ready, 1'b1);
      step();
      dvld = 1'b0; fl = 1'b0;
      chk_word("t5_flush2", 32'h77000000, 4'h8, 1'b1);
      step();

      // sync_n discards a partial word
      dvld = 1'b1;
      din = 8'hE1; step();
      din = 8'hE2; step();
      dvld = 1'b0; sn = 1'b0; fl = 1'b1;
      #1;
      chk("t6_sync_rdy",  ifa.data_in_ready, 1'b0);
      chk("t6_sync_fack", ifa.flush_ack, 1'b0);
      step();
      sn = 1'b1; fl = 1'b0;
      chk("t6_sync_noword", ifa.data_out_valid, 1'b0);
      dvld = 1'b1;
      for (int b = 1; b <= 4; b++) begin
         din = 8'(b);
         step();
      end
      dvld = 1'b0;
      chk_word("t6_after_sync", 32'h01020304, 4'hF, 1'b0);

      // asynchronous reset mid-word with a pending word
      ordy = 1'b0; dvld = 1'b1; din = 8'h09;
      step();
      dvld = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("t7_rst_vld",   ifa.data_out_valid, 1'b0);
      chk("t7_rst_dat",   ifa.data_out, 32'h0);
      chk("t7_rst_keep",  ifa.data_out_keep, 4'h0);
      chk("t7_rst_inrdy", ifa.data_in_ready, 1'b0);
      step();
      rst = 1'b0; ordy = 1'b1;
      dvld = 1'b1;
      din = 8'hA1; step();
      din = 8'hA2; step();
      din = 8'hA3; step();
      din = 8'hA4; step();
      dvld = 1'b0;
      chk_word("t7_after_rst", 32'hA1A2A3A4, 4'hF, 1'b0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
